aes_encrypt_core: RTL and testbench

// - Iterative AES encryption datapath: one round per clock; 128/192/256-bit keys selected by klen_sel.
// - Counterpart to the decryption engine.
// - Consumes forward-order round keys straight from the key expander (KeyExpand128/192/256).
//   No schedule-reversal buffer is needed.
// - Instantiated with a key expander inside the aes_encryptNNN wrappers.

---
 rtl/aes_encrypt_core.sv | 168 ++++++++++++++++
 tb/tb_aes_encrypt_core.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_encrypt_core.sv
// Iterative AES-128/192/256 encryption core: one round per clock, forward-order round keys.
// Optional AES_ENC_SBOX_REG_EN: registers SubBytes+ShiftRows, splitting each round into SUB and MIX cycles.
module aes_encrypt_core (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] pt,
  input  logic         pt_vld,
  output logic         pt_rdy,
  input  logic [127:0] rkey,
  input  logic         rkey_vld,
  output logic         next_rkey,
  input  logic [1:0]   klen_sel,
  output logic [127:0] ct,
  output logic         ct_vld
);

  localparam int unsigned BLK_W = 128;
  localparam int unsigned RND_W = 4;

  // Entry b of the S-box sits at bits [8*(255-b) +: 8].
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {IDLE, ROUND, MIX} state_t;

  state_t             state, state_d;
  logic [BLK_W-1:0]   st, st_d, ct_d, sr_c, rin;
  logic [RND_W-1:0]   rnd, rnd_d, nr, nr_d;
  logic               ct_vld_d, fire;
`ifdef AES_ENC_SBOX_REG_EN
  logic [BLK_W-1:0]   sr_q, sr_d;
`endif

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Byte i of the state is row i%4, column i/4; byte 0 is the MSB.
  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = sbox(s[127-8*(4*((c+r)%4)+r) -: 8]);
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

  always_comb begin
    state_d   = state;
    st_d      = st;
    rnd_d     = rnd;
    nr_d      = nr;
    ct_d      = ct;
    ct_vld_d  = 1'b0;
    next_rkey = 1'b0;
    pt_rdy    = 1'b0;
    fire      = 1'b0;
    sr_c      = sub_shift(st);
`ifdef AES_ENC_SBOX_REG_EN
    sr_d      = sr_q;
    rin       = sr_q;
`else
    rin       = sr_c;
`endif
    case (state)
      IDLE: begin
        pt_rdy = rkey_vld && !rst;
        if (pt_vld && pt_rdy) begin
          next_rkey = 1'b1;
          st_d      = pt ^ rkey;
          rnd_d     = RND_W'(1);
          state_d   = ROUND;
          case (klen_sel)
            2'b01:   nr_d = RND_W'(12);
            2'b10:   nr_d = RND_W'(14);
            default: nr_d = RND_W'(10);
          endcase
        end
      end
      ROUND: begin
`ifdef AES_ENC_SBOX_REG_EN
        sr_d    = sr_c;
        state_d = MIX;
`else
        fire    = rkey_vld;
`endif
      end
      MIX: begin
`ifdef AES_ENC_SBOX_REG_EN
        fire = rkey_vld;
`endif
      end
      default: state_d = IDLE;
    endcase

    // Key-consuming round step; the last round skips MixColumns and retires the block.
    if (fire) begin
      next_rkey = 1'b1;
      if (rnd == nr) begin
        ct_d     = rin ^ rkey;
        ct_vld_d = 1'b1;
        st_d     = '0;
        rnd_d    = '0;
        state_d  = IDLE;
      end else begin
        st_d    = mix_columns(rin) ^ rkey;
        rnd_d   = rnd + RND_W'(1);
        state_d = ROUND;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      st     <= '0;
      rnd    <= '0;
      nr     <= '0;
      ct     <= '0;
      ct_vld <= 1'b0;
`ifdef AES_ENC_SBOX_REG_EN
      sr_q   <= '0;
`endif
    end else begin
      state  <= state_d;
      st     <= st_d;
      rnd    <= rnd_d;
      nr     <= nr_d;
      ct     <= ct_d;
      ct_vld <= ct_vld_d;
`ifdef AES_ENC_SBOX_REG_EN
      sr_q   <= sr_d;
`endif
    end
  end

endmodule

// File: tb/tb_aes_encrypt_core.sv
// Directed bench for aes_encrypt_core with a behavioural forward key source (FIPS-197 C.1/C.2/C.3).
// Honours AES_ENC_SBOX_REG_EN for expected latency, block period and stall growth.
module tb_aes_encrypt_core;

`ifdef AES_ENC_SBOX_REG_EN
  localparam int LAT_MUL   = 2;
  localparam int STALL_ADD = 4;
`else
  localparam int LAT_MUL   = 1;
  localparam int STALL_ADD = 5;
`endif

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
  localparam logic [255:0] KEY128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] KEY192 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
  localparam logic [255:0] KEY256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT192  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] pt;
  logic         pt_vld;
  logic         pt_rdy;
  logic [127:0] rkey;
  logic         rkey_vld;
  logic         next_rkey;
  logic [1:0]   klen_sel;
  logic [127:0] ct;
  logic         ct_vld;

  int vectors     = 0;
  int miscompares = 0;

  aes_encrypt_core dut (
    .clk(clk), .rst(rst), .pt(pt), .pt_vld(pt_vld), .pt_rdy(pt_rdy),
    .rkey(rkey), .rkey_vld(rkey_vld), .next_rkey(next_rkey),
    .klen_sel(klen_sel), .ct(ct), .ct_vld(ct_vld)
  );

  always #5 clk = ~clk;

  // Key source: presents key 0 after reset/load, advances on each strobe, wraps after key Nr.
  logic [127:0] rk [0:14];
  logic [3:0]   kidx;
  logic         kload = 1'b0;
  int           nr_tb = 10;
  assign rkey = rk[kidx];

  always @(posedge clk or posedge rst) begin
    if (rst)            kidx <= 4'd0;
    else if (kload)     kidx <= 4'd0;
    else if (next_rkey) kidx <= (kidx == 4'(nr_tb)) ? 4'd0 : kidx + 4'd1;
  end

  // Mid-cycle monitor: edge count, accept edges, completions, key strobes.
  int           cyc = 0;
  int           accepts = 0;
  int           cts = 0;
  int           strobes = 0;
  int           acc_edge [0:63];
  int           ct_edge  [0:63];
  logic [127:0] ct_hist  [0:63];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (next_rkey) strobes <= strobes + 1;
    if (pt_vld && pt_rdy && accepts < 64) begin
      acc_edge[accepts] <= cyc + 1;
      accepts <= accepts + 1;
    end
    if (ct_vld && cts < 64) begin
      ct_edge[cts] <= cyc;
      ct_hist[cts] <= ct;
      cts <= cts + 1;
    end
  end

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {SBOX[{~w[31:24], 3'b000} +: 8], SBOX[{~w[23:16], 3'b000} +: 8],
            SBOX[{~w[15:8], 3'b000} +: 8],  SBOX[{~w[7:0], 3'b000} +: 8]};
  endfunction

  task automatic load_key(input logic [255:0] key, input int nk, input logic [1:0] ks);
    logic [31:0] w [0:59];
    logic [31:0] t;
    logic [7:0]  rc;
    int          nr;
    nr = nk + 6;
    rkey_vld = 1'b0;
    klen_sel = ks;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    rc = 8'h01;
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end else if (nk > 6 && i % nk == 4) begin
        t = sub_word(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r <= nr; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    nr_tb = nr;
    kload = 1'b1;
    @(posedge clk); #1;
    kload = 1'b0;
    rkey_vld = 1'b1;
  endtask

  // Offers one block, switches klen_sel after acceptance, waits (bounded) for its completion.
  task automatic run_block(input logic [127:0] p, input logic [1:0] klen_after, output logic ok);
    int a0, c0, n;
    a0 = accepts; c0 = cts; n = 0;
    pt = p; pt_vld = 1'b1;
    while (accepts == a0 && n < 100) begin @(posedge clk); #1; n++; end
    pt_vld = 1'b0;
    klen_sel = klen_after;
    while (cts == c0 && n < 100) begin @(posedge clk); #1; n++; end
    ok = (accepts == a0 + 1) && (cts == c0 + 1);
  endtask

  task automatic test_reset;
    rst = 1'b1; pt = '0; pt_vld = 1'b0; rkey_vld = 1'b1; klen_sel = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    vectors++; if (ct !== 128'h0) begin miscompares++; $display("FAIL reset_ct: got %h want 0", ct); end
    vectors++; if (ct_vld !== 1'b0) begin miscompares++; $display("FAIL reset_ct_vld: got %b want 0", ct_vld); end
    vectors++; if (pt_rdy !== 1'b0) begin miscompares++; $display("FAIL reset_pt_rdy: got %b want 0", pt_rdy); end
    vectors++; if (next_rkey !== 1'b0) begin miscompares++; $display("FAIL reset_next_rkey: got %b want 0", next_rkey); end
    rst = 1'b0;
    #1;
    vectors++; if (pt_rdy !== 1'b1) begin miscompares++; $display("FAIL post_reset_pt_rdy: got %b want 1", pt_rdy); end
    @(posedge clk); #1;
  endtask

  task automatic test_known_answer(input string name, input logic [255:0] key, input int nk,
                                   input logic [1:0] ks, input logic [1:0] klen_after,
                                   input logic [127:0] exp_ct);
    logic ok;
    int   s0, lat;
    load_key(key, nk, ks);
    s0 = strobes;
    run_block(PT, klen_after, ok);
    lat = ct_edge[cts-1] - acc_edge[accepts-1];
    vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL %s_done: got %b want 1", name, ok); end
    vectors++; if (ct !== exp_ct) begin miscompares++; $display("FAIL %s_ct: got %h want %h", name, ct, exp_ct); end
    vectors++; if (lat !== LAT_MUL*(nk+6)) begin miscompares++; $display("FAIL %s_latency: got %0d want %0d", name, lat, LAT_MUL*(nk+6)); end
    vectors++; if (strobes - s0 !== nk + 7) begin miscompares++; $display("FAIL %s_strobes: got %0d want %0d", name, strobes - s0, nk + 7); end
    vectors++; if (ct_vld !== 1'b0) begin miscompares++; $display("FAIL %s_pulse_width: ct_vld got %b want 0", name, ct_vld); end
  endtask

  task automatic test_back_to_back;
    int a0, c0, s0, n, gap;
    load_key(KEY256, 8, 2'b10);
    a0 = accepts; c0 = cts; s0 = strobes; n = 0;
    pt = PT; pt_vld = 1'b1;
    while (accepts < a0 + 3 && n < 300) begin @(posedge clk); #1; n++; end
    pt_vld = 1'b0;
    while (cts < c0 + 3 && n < 300) begin @(posedge clk); #1; n++; end
    vectors++; if (accepts - a0 !== 3) begin miscompares++; $display("FAIL b2b_accepts: got %0d want 3", accepts - a0); end
    vectors++; if (cts - c0 !== 3) begin miscompares++; $display("FAIL b2b_completions: got %0d want 3", cts - c0); end
    for (int i = 1; i < 3; i++) begin
      gap = acc_edge[a0+i] - acc_edge[a0+i-1];
      vectors++; if (gap !== LAT_MUL*14 + 1) begin miscompares++; $display("FAIL b2b_gap%0d: got %0d want %0d", i, gap, LAT_MUL*14 + 1); end
    end
    for (int i = 0; i < 3; i++) begin
      vectors++; if (ct_hist[c0+i] !== CT256) begin miscompares++; $display("FAIL b2b_ct%0d: got %h want %h", i, ct_hist[c0+i], CT256); end
    end
    vectors++; if (strobes - s0 !== 45) begin miscompares++; $display("FAIL b2b_strobes: got %0d want 45", strobes - s0); end
  endtask

  task automatic test_stall;
    int a0, c0, s0, s_mid, n, lat;
    a0 = accepts; c0 = cts; s0 = strobes; n = 0;
    pt = PT; pt_vld = 1'b1;
    while (accepts == a0 && n < 100) begin @(posedge clk); #1; n++; end
    pt_vld = 1'b0;
    while (strobes - s0 < 7 && n < 100) begin @(posedge clk); #1; n++; end
    rkey_vld = 1'b0;
    s_mid = strobes;
    repeat (5) @(posedge clk);
    #1;
    vectors++; if (strobes !== s_mid) begin miscompares++; $display("FAIL stall_strobes: got %0d want %0d", strobes, s_mid); end
    vectors++; if (pt_rdy !== 1'b0) begin miscompares++; $display("FAIL stall_pt_rdy: got %b want 0", pt_rdy); end
    rkey_vld = 1'b1;
    while (cts == c0 && n < 100) begin @(posedge clk); #1; n++; end
    lat = ct_edge[cts-1] - acc_edge[accepts-1];
    vectors++; if (cts - c0 !== 1) begin miscompares++; $display("FAIL stall_done: got %0d want 1", cts - c0); end
    vectors++; if (ct !== CT256) begin miscompares++; $display("FAIL stall_ct: got %h want %h", ct, CT256); end
    vectors++; if (lat !== LAT_MUL*14 + STALL_ADD) begin miscompares++; $display("FAIL stall_latency: got %0d want %0d", lat, LAT_MUL*14 + STALL_ADD); end
    vectors++; if (strobes - s0 !== 15) begin miscompares++; $display("FAIL stall_total_strobes: got %0d want 15", strobes - s0); end
    rkey_vld = 1'b0;
    #1;
    vectors++; if (pt_rdy !== 1'b0) begin miscompares++; $display("FAIL idle_nokey_pt_rdy: got %b want 0", pt_rdy); end
    rkey_vld = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_block;
    int   a0, c0, s0, n;
    logic ok;
    a0 = accepts; c0 = cts; s0 = strobes; n = 0;
    pt = PT; pt_vld = 1'b1;
    while (accepts == a0 && n < 100) begin @(posedge clk); #1; n++; end
    pt_vld = 1'b0;
    while (strobes - s0 < 9 && n < 100) begin @(posedge clk); #1; n++; end
    rst = 1'b1;
    @(posedge clk); #1;
    vectors++; if (ct !== 128'h0) begin miscompares++; $display("FAIL midrst_ct: got %h want 0", ct); end
    vectors++; if (next_rkey !== 1'b0) begin miscompares++; $display("FAIL midrst_next_rkey: got %b want 0", next_rkey); end
    rst = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    vectors++; if (cts !== c0) begin miscompares++; $display("FAIL midrst_no_pulse: got %0d completions want 0", cts - c0); end
    vectors++; if (ct !== 128'h0) begin miscompares++; $display("FAIL midrst_ct_hold: got %h want 0", ct); end
    run_block(PT, 2'b10, ok);
    vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL midrst_next_done: got %b want 1", ok); end
    vectors++; if (ct !== CT256) begin miscompares++; $display("FAIL midrst_next_ct: got %h want %h", ct, CT256); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_known_answer("c3", KEY256, 8, 2'b10, 2'b00, CT256);
    test_known_answer("c1", KEY128, 4, 2'b00, 2'b10, CT128);
    test_known_answer("c2", KEY192, 6, 2'b01, 2'b01, CT192);
    test_back_to_back();
    test_stall();
    test_reset_mid_block();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
